seven_seg_display: RTL and testbench

SEVEN_SEG_DISPLAY -- requirements
Module: seven_seg_display

---
 rtl/seven_seg_display.sv | 122 ++++++++++++
 tb/tb_seven_seg_display.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display.sv
// seven_seg_display: binary to decimal/hex seven-segment driver with overflow dashes and leading-zero blanking.
module seven_seg_display #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [WIDTH-1:0]      i_value,
    input  logic                  i_hex_mode,
    input  logic                  i_blank_lz,
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [DIGITS*7-1:0]   o_seven
);
    function automatic int dec_digits(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1011000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction

    // The BCD register holds every decimal digit WIDTH bits can produce, so hex nibbles always fit too.
    localparam int BD  = dec_digits(WIDTH);
    localparam int BW  = 4 * BD;
    localparam int EXT = BD > DIGITS ? BD : DIGITS;
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;
    state_t state, state_nxt;
    logic [BW-1:0] bcd, bcd_adj;
    logic [WIDTH-1:0] bin;
    logic [CW-1:0] cnt;
    logic blank_q;
    logic [4*EXT-1:0] ext;
    logic [DIGITS*7-1:0] seven_nxt;
    logic ovf, run;
    logic [3:0] d;

    always_ff @(posedge i_clk)
        state <= !i_rst_n ? IDLE : state_nxt;

    always_comb begin
        state_nxt = (state == IDLE) ? (i_valid ? (i_hex_mode ? OUT : CONV) : IDLE) :
                    (state == CONV) ? (cnt == CW'(WIDTH - 1) ? OUT : CONV) : IDLE;
    end

    always_comb begin
        o_ready = state == IDLE;
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BD; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // Walk from the top digit down so run stays set only while every digit at or above is zero.
    always_comb begin
        ext = '0;
        ext[BW-1:0] = bcd;
        ovf = (ext >> (4 * DIGITS)) != '0;
        run = 1'b1;
        d = '0;
        seven_nxt = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = ext[4*i +: 4];
            run = run && d == 4'd0;
            seven_nxt[7*i +: 7] = ovf ? 7'b0111111 : (blank_q && i != 0 && run) ? 7'b1111111 : seg(d);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_seven    <= '1;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_done <= state == OUT;
            if (state == IDLE && i_valid) begin
                bin     <= i_value;
                bcd     <= i_hex_mode ? BW'(i_value) : '0;
                cnt     <= '0;
                blank_q <= i_blank_lz;
            end else if (state == CONV) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                cnt        <= cnt + 1'b1;
            end
            if (state == OUT) begin
                o_seven    <= seven_nxt;
                o_overflow <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_display.sv
// tb_seven_seg_display: scoreboard bench for seven_seg_display at DIGITS=4, WIDTH=16.
module tb_seven_seg_display;
    logic i_clk = 0, i_rst_n = 0, i_valid = 0, i_hex_mode = 0, i_blank_lz = 0;
    logic [15:0] i_value = '0;
    logic o_ready, o_done, o_overflow;
    logic [27:0] o_seven;
    int total = 0, bad = 0, cyc = 0;

    typedef struct {logic [27:0] seven; logic ovf; int at;} exp_t;
    exp_t q[$];
    exp_t e;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DA = 7'b0111111;

    seven_seg_display #(.DIGITS(4), .WIDTH(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_value(i_value),
        .i_hex_mode(i_hex_mode), .i_blank_lz(i_blank_lz), .o_ready(o_ready),
        .o_done(o_done), .o_overflow(o_overflow), .o_seven(o_seven));

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Digit i is blank when blanking is on and the value has no digit at position i.
    function automatic logic [28:0] model(input int v, input bit h, input bit b);
        int base, p;
        logic [28:0] r;
        base = h ? 16 : 10;
        p = 1;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[7*i +: 7] = (i > 0 && b && v < p) ? BL : SEG[(v / p) % base];
            p *= base;
        end
        if (v >= p) r = {1'b1, DA, DA, DA, DA};
        return r;
    endfunction

    always @(posedge i_clk) begin
        cyc++;
        #1;
        if (o_done) begin
            if (q.size() == 0) check("spurious_done", 1, 0);
            else begin
                e = q.pop_front();
                check("seven", o_seven, e.seven);
                check("ovf", o_overflow, e.ovf);
                check("latency", cyc, e.at);
            end
        end
    end

    task automatic send(input int v, input bit h, input bit b);
        int n;
        logic [28:0] m;
        exp_t x;
        n = 0;
        while (!o_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("ready_wait", o_ready, 1);
        i_valid = 1;
        i_value = v[15:0];
        i_hex_mode = h;
        i_blank_lz = b;
        m = model(v, h, b);
        x.seven = m[27:0];
        x.ovf = m[28];
        x.at = cyc + 1 + (h ? 1 : 17);
        q.push_back(x);
        @(negedge i_clk);
        i_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        int hi;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1;
        check("rst_seven", o_seven, {28{1'b1}});
        check("rst_done", o_done, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_ready", o_ready, 1);

        send(1234, 0, 0);
        hi = 0;
        repeat (17) begin
            if (o_ready) hi++;
            @(negedge i_clk);
        end
        check("busy_ready", hi, 0);
        drain();
        check("lit_1234", o_seven, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

        send(42, 0, 1);
        drain();
        check("lit_42_blz", o_seven, {BL, BL, SEG[4], SEG[2]});
        send(42, 0, 0);
        drain();
        check("lit_42", o_seven, {SEG[0], SEG[0], SEG[4], SEG[2]});
        send(0, 0, 1);
        drain();
        check("lit_0_blz", o_seven, {BL, BL, BL, SEG[0]});

        send(16'hBEEF, 1, 0);
        i_value = 16'h1234;
        drain();
        check("lit_beef", o_seven, {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110});

        send(12345, 0, 0);
        drain();
        check("lit_ovf", o_seven, {DA, DA, DA, DA});
        check("lit_ovf_flag", o_overflow, 1);
        send(9999, 0, 0);
        drain();
        repeat (5) @(negedge i_clk);
        check("lit_9999", o_seven, {SEG[9], SEG[9], SEG[9], SEG[9]});
        check("lit_9999_flag", o_overflow, 0);

        send(1234, 0, 0);
        i_valid = 1;
        i_value = 16'd5555;
        send(5555, 0, 0);
        drain();
        check("lit_5555", o_seven, {SEG[5], SEG[5], SEG[5], SEG[5]});

        repeat (6) send(int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();

        send(1234, 0, 1);
        repeat (7) @(negedge i_clk);
        i_rst_n = 0;
        q.delete();
        @(negedge i_clk);
        i_rst_n = 1;
        check("abort_seven", o_seven, {28{1'b1}});
        check("abort_ready", o_ready, 1);
        check("abort_ovf", o_overflow, 0);
        hi = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_done) hi++;
        end
        check("abort_done", hi, 0);
        check("abort_hold", o_seven, {28{1'b1}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
